// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO block with per-pin direction, set/clear strobes and edge interrupts.
// Define WB_GPIO_IRQ_EN to build the edge-detect / interrupt registers (addresses 5-7).
module wb_gpio_irq #(
    parameter int          GPIO_WIDTH    = 18,
    parameter logic [31:0] DIR_RESET_VAL = 32'h0,
    parameter logic [31:0] OUT_RESET_VAL = 32'h0,
    parameter int          WB_DAT_WIDTH  = 32,
    parameter int          WB_ADR_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WB_ADR_WIDTH-1:0] wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0] wb_dat_i,
    input  logic                    wb_we_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    output logic                    wb_ack_o,
    output logic [WB_DAT_WIDTH-1:0] wb_dat_o,
    inout  wire  [GPIO_WIDTH-1:0]   gpio_io,
    output logic                    irq
);

    localparam logic [GPIO_WIDTH-1:0] DIR_RST = DIR_RESET_VAL[GPIO_WIDTH-1:0];
    localparam logic [GPIO_WIDTH-1:0] OUT_RST = OUT_RESET_VAL[GPIO_WIDTH-1:0];

    localparam logic [2:0] ADR_DATA_IN  = 3'd0;
    localparam logic [2:0] ADR_DATA_OUT = 3'd1;
    localparam logic [2:0] ADR_DIR      = 3'd2;
    localparam logic [2:0] ADR_OUT_SET  = 3'd3;
    localparam logic [2:0] ADR_OUT_CLR  = 3'd4;
`ifdef WB_GPIO_IRQ_EN
    localparam logic [2:0] ADR_RISE_EN  = 3'd5;
    localparam logic [2:0] ADR_FALL_EN  = 3'd6;
    localparam logic [2:0] ADR_STATUS   = 3'd7;
`endif

    logic                    ack_reg;
    logic [WB_DAT_WIDTH-1:0] dat_reg;
    logic [GPIO_WIDTH-1:0]   data_out_reg, data_out_next;
    logic [GPIO_WIDTH-1:0]   dir_reg, dir_next;
    logic [GPIO_WIDTH-1:0]   sync1_reg, sync2_reg;
    logic [WB_DAT_WIDTH-1:0] rd_data;

    logic                  req, access, wr;
    logic [2:0]            adr;
    logic [GPIO_WIDTH-1:0] wdat;
    logic                  unused_bits;

    assign req         = wb_cyc_i & wb_stb_i;
    assign access      = req & ~ack_reg;
    assign wr          = access & wb_we_i;
    assign adr         = wb_adr_i[4:2];
    assign wdat        = wb_dat_i[GPIO_WIDTH-1:0];
    assign unused_bits = ^{wb_adr_i, wb_dat_i};

    assign wb_ack_o = req & ack_reg;
    assign wb_dat_o = dat_reg;

    for (genvar gi = 0; gi < GPIO_WIDTH; gi++) begin : g_pad
        assign gpio_io[gi] = dir_reg[gi] ? data_out_reg[gi] : 1'bz;
    end

    always_comb begin
        data_out_next = data_out_reg;
        dir_next      = dir_reg;
        if (wr) begin
            case (adr)
                ADR_DATA_OUT: data_out_next = wdat;
                ADR_DIR:      dir_next      = wdat;
                ADR_OUT_SET:  data_out_next = data_out_reg | wdat;
                ADR_OUT_CLR:  data_out_next = data_out_reg & ~wdat;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_reg      <= 1'b0;
            dat_reg      <= '0;
            data_out_reg <= OUT_RST;
            dir_reg      <= DIR_RST;
            sync1_reg    <= '0;
            sync2_reg    <= '0;
        end else begin
            ack_reg      <= access;
            if (access) begin
                dat_reg <= rd_data;
            end
            data_out_reg <= data_out_next;
            dir_reg      <= dir_next;
            sync1_reg    <= gpio_io;
            sync2_reg    <= sync1_reg;
        end
    end

`ifdef WB_GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0] rise_en_reg, rise_en_next;
    logic [GPIO_WIDTH-1:0] fall_en_reg, fall_en_next;
    logic [GPIO_WIDTH-1:0] status_reg, status_next;
    logic [GPIO_WIDTH-1:0] prev_reg;
    logic [GPIO_WIDTH-1:0] event_set;

    // Only input pins can raise events; prev follows sync2 so a DIR flip alone is not an edge.
    assign event_set = ~dir_reg & ((sync2_reg & ~prev_reg & rise_en_reg) |
                                   (~sync2_reg & prev_reg & fall_en_reg));

    always_comb begin
        rise_en_next = rise_en_reg;
        fall_en_next = fall_en_reg;
        status_next  = status_reg;
        if (wr) begin
            case (adr)
                ADR_RISE_EN: rise_en_next = wdat;
                ADR_FALL_EN: fall_en_next = wdat;
                ADR_STATUS:  status_next  = status_reg & ~wdat;
                default:     ;
            endcase
        end
        // A fresh event beats a simultaneous write-1-to-clear.
        status_next = status_next | event_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rise_en_reg <= '0;
            fall_en_reg <= '0;
            status_reg  <= '0;
            prev_reg    <= '0;
        end else begin
            rise_en_reg <= rise_en_next;
            fall_en_reg <= fall_en_next;
            status_reg  <= status_next;
            prev_reg    <= sync2_reg;
        end
    end

    assign irq = |status_reg;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        case (adr)
            ADR_DATA_IN:  rd_data[GPIO_WIDTH-1:0] = sync2_reg;
            ADR_DATA_OUT: rd_data[GPIO_WIDTH-1:0] = data_out_reg;
            ADR_DIR:      rd_data[GPIO_WIDTH-1:0] = dir_reg;
`ifdef WB_GPIO_IRQ_EN
            ADR_RISE_EN:  rd_data[GPIO_WIDTH-1:0] = rise_en_reg;
            ADR_FALL_EN:  rd_data[GPIO_WIDTH-1:0] = fall_en_reg;
            ADR_STATUS:   rd_data[GPIO_WIDTH-1:0] = status_reg;
`endif
            default:      ;
        endcase
    end

endmodule

// File: doc/wb_gpio_irq.md
WB_GPIO_IRQ -- requirements
Module: wb_gpio_irq

Interface
REQ-001 Parameter GPIO_WIDTH, default 18: number of GPIO pins, legal range 1..32.
REQ-002 Parameter DIR_RESET_VAL, default 0: DIR register reset value (1 = output).
REQ-003 Parameter OUT_RESET_VAL, default 0: DATA_OUT register reset value.
REQ-004 Parameter WB_DAT_WIDTH, default 32: Wishbone data width, fixed at 32.
REQ-005 Parameter WB_ADR_WIDTH, default 32: Wishbone byte address width.
REQ-006 clk  input  1  single system clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, asynchronous assert, active-low.
REQ-008 wb_adr_i  input  WB_ADR_WIDTH  byte address; only bits [4:2] are decoded.
REQ-009 wb_dat_i  input  32  write data.
REQ-010 wb_we_i  input  1  1 = write, 0 = read.
REQ-011 wb_cyc_i  input  1  bus cycle valid.
REQ-012 wb_stb_i  input  1  strobe.
REQ-013 wb_ack_o  output  1  transfer acknowledge.
REQ-014 wb_dat_o  output  32  registered read data.
REQ-015 gpio_io  inout  GPIO_WIDTH  pads; bit i is driven by DATA_OUT[i] when DIR[i]=1, otherwise high-Z.
REQ-016 irq  output  1  level interrupt, equal to the OR of IRQ_STATUS bits.

Function
REQ-017 Register map by wb_adr_i[4:2]: 0 DATA_IN (RO), 1 DATA_OUT (RW), 2 DIR (RW), 3 OUT_SET (WO), 4 OUT_CLR (WO), 5 IRQ_RISE_EN (RW), 6 IRQ_FALL_EN (RW), 7 IRQ_STATUS (R/W1C).
REQ-018 Register bits [31:GPIO_WIDTH] SHALL read 0; writes to them SHALL be ignored; reads of WO registers SHALL return 0.
REQ-019 Handshake: a request (cyc&stb) with internal ack=0 SHALL set ack on the next edge; wb_ack_o = cyc&stb&ack; ack lasts one cycle, so back-to-back requests ack every second cycle.
REQ-020 Read data SHALL be loaded into wb_dat_o on the same edge that sets ack; wb_dat_o holds its value otherwise.
REQ-021 Write side effects SHALL take place exactly once, on the edge that sets ack.
REQ-022 Every pad SHALL pass through a 2-flop synchronizer (sync1, sync2); DATA_IN returns sync2, so a pad change sampled at edge N is readable after edge N+1.
REQ-023 prev SHALL register sync2 each cycle; rise[i] = sync2&~prev&~DIR[i]&RISE_EN[i]; fall[i] = ~sync2&prev&~DIR[i]&FALL_EN[i].
REQ-024 IRQ_STATUS[i] SHALL be set on the edge after rise[i] or fall[i] is true (pad change sampled at edge N gives status at edge N+2).
REQ-025 OUT_SET writes SHALL set DATA_OUT bits where data=1; OUT_CLR writes SHALL clear them; zero bits are unchanged.
REQ-026 If a W1C write and a new event hit the same status bit on the same edge, set SHALL win.
REQ-027 Output pins (DIR=1) SHALL never set status; changing DIR SHALL NOT itself generate an event while prev tracks sync2.
REQ-028 irq SHALL be combinational from the IRQ_STATUS flops (no extra latency).

Reset
REQ-029 On rst=0, asynchronously: DATA_OUT=OUT_RESET_VAL, DIR=DIR_RESET_VAL, RISE_EN=FALL_EN=STATUS=0, sync1=sync2=prev=0, ack=0, wb_dat_o=0, so irq=0 and wb_ack_o=0.
REQ-030 Reset during an active bus cycle SHALL abort it: no ack, no write side effect; after release the master reissues.
REQ-031 The first edge after release SHALL behave as a normal cycle; edges present on the pads at release are not reported because enables are 0.

Configuration
REQ-032 Macro WB_GPIO_IRQ_EN defined: registers 5-7, edge logic and irq are present as specified.
REQ-033 WB_GPIO_IRQ_EN undefined: addresses 5-7 read 0 and ignore writes but still ack; irq is tied 0; prev and the edge logic are removed; DATA_IN keeps the 2-flop synchronizer.

Verification
REQ-034 Write DIR=0x3FFFF, DATA_OUT=0x00A5 -> gpio_io=0x000A5 one cycle after ack; DATA_IN reads 0x000A5.
REQ-035 DATA_OUT=0x0F0, write OUT_SET=0x003, then OUT_CLR=0x030 -> DATA_OUT reads 0x0C3.
REQ-036 DIR=0, RISE_EN[4]=1, drive pad4 0->1 sampled at edge N -> STATUS=0x10 and irq=1 at edge N+2; W1C 0x10 -> irq=0.
REQ-037 FALL_EN[0]=1 with a pad0 fall timed so the event coincides with a W1C of bit 0 -> STATUS[0] stays 1.
REQ-038 rst low mid-read with a write pending -> wb_ack_o=0 and all registers at reset values; a repeated write after release acks once.
REQ-039 Build without WB_GPIO_IRQ_EN, write 0xFFFFFFFF to address 5 then read it -> returns 0x0; toggling pads never asserts irq.
